// File: rtl/my_ram_pkg.sv
// Definitions shared by the RAM family (RAM, and later the ROM and screen memory).
package my_ram_pkg;

    typedef enum logic {
        RAM_CLEAR = 1'b0,
        RAM_IDLE  = 1'b1
    } ram_state_t;

    localparam int RAM_MAX_ADDR_W = 16;

    function automatic int ram_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/my_ram_clear_seq.sv
// Clear-sweep sequencer: walks ptr from 0 to done_ptr, one word per clock, then raises ready.
module my_ram_clear_seq
    import my_ram_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] done_ptr,
    output logic [ADDR_W-1:0] ptr,
    output logic              clr_we,
    output logic              ready
);

    ram_state_t        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_ready;

    // ptr holds at done_ptr instead of wrapping; IDLE is left only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RAM_CLEAR;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else if (r_state == RAM_CLEAR) begin
            if (r_ptr == done_ptr) begin
                r_state <= RAM_IDLE;
                r_ready <= 1'b1;
            end else begin
                r_ptr <= r_ptr + ADDR_W'(1);
            end
        end
    end

    assign ptr    = r_ptr;
    assign clr_we = (r_state == RAM_CLEAR);
    assign ready  = r_ready;

endmodule

// File: rtl/my_ram_n.sv
// Parametrised single-port RAM: combinational read, clocked write, and a
// reset-triggered clear sweep that holds ready low until every word is defined.
module my_ram_n
    import my_ram_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               ADDR_W    = 6,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
    output logic [WIDTH-1:0]  out,
    output logic              ready
);

    localparam int DEPTH = ram_depth(ADDR_W);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] w_clr_ptr;
    logic              w_clr_we;
    logic              w_ready;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [WIDTH-1:0]  w_wdata;

    my_ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .done_ptr ({ADDR_W{1'b1}}),
        .ptr      (w_clr_ptr),
        .clr_we   (w_clr_we),
        .ready    (w_ready)
    );

    // The sweep owns the write port while clearing; a reset edge writes nothing.
    always_comb begin
        w_waddr = addr;
        w_wdata = in;
        w_we    = load & w_ready;
        if (w_clr_we) begin
            w_waddr = w_clr_ptr;
            w_wdata = CLEAR_VAL;
            w_we    = 1'b1;
        end
        if (reset) begin
            w_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign out   = w_ready ? r_mem[addr] : CLEAR_VAL;
    assign ready = w_ready;

endmodule

// File: tb/tb_my_ram_n.sv
// Scoreboard bench for my_ram_n: three parameterisations driven in parallel, each
// against an array model; a single monitor pops expectations and compares.
module tb_my_ram_n;

    typedef struct packed {
        logic        rdy;
        logic [31:0] data;
        logic [15:0] addr;
        logic [7:0]  scn;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t        sbq [3][$];
    logic [31:0] mon_out [3];
    logic        mon_rdy [3];
    logic        mon_chk [3];
    logic        hdone   [3];
    logic        fin_req = 1'b0;
    logic        fin_ack = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : h
        localparam int W = (g == 0) ? 16 : (g == 1) ? 8 : 32;
        localparam int A = (g == 0) ? 6 : (g == 1) ? 1 : 10;
        localparam int D = 1 << A;
        localparam logic [W-1:0] CV = (g == 0) ? W'(32'hA5A5) :
                                      (g == 1) ? W'(32'h3C) : W'(32'hDEAD0F0F);

        logic         reset, load, chk, rdy, fin;
        logic [W-1:0] din, dout;
        logic [A-1:0] addr;

        // Model: cnt counts non-reset edges since the last reset; contents are
        // defined (all CV) once cnt reaches D, and only then do writes land.
        logic [W-1:0] model [D];
        int           cnt = -1;

        my_ram_n #(
            .WIDTH     (W),
            .ADDR_W    (A),
            .CLEAR_VAL (CV)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .in    (din),
            .addr  (addr),
            .load  (load),
            .out   (dout),
            .ready (rdy)
        );

        assign mon_out[g] = 32'(dout);
        assign mon_rdy[g] = rdy;
        assign mon_chk[g] = chk;
        assign hdone[g]   = fin;

        task automatic step(input logic r, input logic l, input int a,
                            input logic [W-1:0] d, input int s);
            exp_t x;
            reset = r;
            load  = l;
            addr  = A'(a);
            din   = d;
            chk   = 1'b1;
            x.rdy  = (cnt == D);
            x.data = 32'((cnt == D) ? model[A'(a)] : CV);
            x.addr = 16'(A'(a));
            x.scn  = 8'(s);
            sbq[g].push_back(x);
            @(posedge clk);
            if (r) begin
                cnt = 0;
            end else if (cnt < D) begin
                cnt++;
                if (cnt == D) foreach (model[i]) model[i] = CV;
            end else if (l) begin
                model[A'(a)] = d;
            end
            #1;
        endtask

        task automatic sweep(input int n, input int s);
            for (int i = 0; i < n; i++) step(1'b0, 1'b0, int'($urandom_range(0, D - 1)), '0, s);
        endtask

        initial begin
            fin = 1'b0; chk = 1'b0; reset = 1'b1; load = 1'b0; addr = '0; din = '0;
            @(posedge clk);
            cnt = 0;
            #1;
            if (g == 0) begin
                // 1: sweep length and cleared contents
                sweep(D, 1);
                for (int i = 0; i < D; i++) step(1'b0, 1'b0, i, '0, 1);
                // 2: write/read, old value visible before the edge
                step(1'b0, 1'b1, 5, W'(32'h1234), 2);
                step(1'b0, 1'b0, 5, '0, 2);
                step(1'b0, 1'b1, 63, W'(32'hFFFF), 2);
                step(1'b0, 1'b0, 63, '0, 2);
                step(1'b0, 1'b0, 4, '0, 2);
                // 3: write attempted mid-sweep is dropped
                step(1'b1, 1'b0, 0, '0, 3);
                sweep(9, 3);
                step(1'b0, 1'b1, 40, W'(32'hBEEF), 3);
                sweep(D - 10, 3);
                step(1'b0, 1'b0, 40, '0, 3);
                // 4: re-reset mid-sweep restarts from word 0
                for (int i = 0; i < D; i++) step(1'b0, 1'b1, i, W'(32'h0001), 4);
                step(1'b1, 1'b0, 0, '0, 4);
                sweep(30, 4);
                step(1'b1, 1'b0, 0, '0, 4);
                sweep(D, 4);
                for (int i = 0; i < D; i++) step(1'b0, 1'b0, i, '0, 4);
                // 5: reset wins over load
                step(1'b0, 1'b1, 7, W'(32'h1111), 5);
                step(1'b1, 1'b1, 7, W'(32'h7777), 5);
                for (int i = 0; i < D; i++) step(1'b0, 1'b1, 7, W'(32'h7777), 5);
                step(1'b0, 1'b0, 7, '0, 5);
            end else begin
                sweep(D, 6);
            end
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 63) == 0) begin
                    step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)), W'($urandom), 7);
                    sweep(D, 7);
                end else begin
                    step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)), W'($urandom), 7);
                end
            end
            chk = 1'b0;
            fin = 1'b1;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (mon_chk[k]) begin
                    if (sbq[k].size() == 0) begin
                        errors++;
                        $display("FAIL dut%0d scoreboard empty: got ready=%b out=%h, expected a queued entry",
                                 k, mon_rdy[k], mon_out[k]);
                    end else begin
                        e = sbq[k].pop_front();
                        checks++;
                        if (mon_rdy[k] !== e.rdy || mon_out[k] !== e.data) begin
                            errors++;
                            $display("FAIL dut%0d scn%0d addr=%0d: got ready=%b out=%h, expected ready=%b out=%h",
                                     k, e.scn, e.addr, mon_rdy[k], mon_out[k], e.rdy, e.data);
                        end
                    end
                end
            end
            if (fin_req && !fin_ack) begin
                checks++;
                if (!(hdone[0] && hdone[1] && hdone[2]) ||
                    (sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0) begin
                    errors++;
                    $display("FAIL completion: got done=%b%b%b pending=%0d, expected done=111 pending=0",
                             hdone[0], hdone[1], hdone[2],
                             sbq[0].size() + sbq[1].size() + sbq[2].size());
                end
                fin_ack = 1'b1;
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(hdone[0] === 1'b1 && hdone[1] === 1'b1 && hdone[2] === 1'b1) && cyc < 50000) begin
            @(posedge clk);
            cyc++;
        end
        fin_req = 1'b1;
        wait (fin_ack);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
